// File: rtl/data_consolidation_pkg.sv
// Shared defaults for the 2-bit to 8-bit symbol packer.
package data_consolidation_pkg;

   localparam int DEF_DIN_W  = 2;
   localparam int DEF_RATIO  = 4;
   localparam int DEF_CNT_W  = $clog2(DEF_RATIO);
   localparam int DEF_DOUT_W = DEF_DIN_W * DEF_RATIO;

   // True when r is a power of two and at least 2 (valid symbols-per-word).
   function automatic bit ratio_ok(input int r);
      return (r >= 2) && ((r & (r - 1)) == 0);
   endfunction

endpackage

// File: rtl/data_consolidation.sv
// Serial-to-parallel packer: collects RATIO valid DIN_W-bit symbols into one
// word. The first symbol lands in the MSBs. The word is strobed with a
// one-cycle dout_en on the same edge that accepts the last symbol.
module data_consolidation
   import data_consolidation_pkg::*;
#(
   parameter int DIN_W = DEF_DIN_W,
   parameter int RATIO = DEF_RATIO
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [DIN_W-1:0]         din,
   input  logic                     din_en,
   output logic [DIN_W*RATIO-1:0]   dout,
   output logic                     dout_en
);

   localparam int DOUT_W = DIN_W * RATIO;
   localparam int CNT_W  = $clog2(RATIO);
   localparam int SR_W   = DOUT_W - DIN_W;

   // A counter width of log2(RATIO) only wraps correctly for powers of two.
   if (!ratio_ok(RATIO)) begin : g_bad_ratio
      $error("data_consolidation: RATIO must be a power of two >= 2");
   end

   // Only the RATIO-1 most recent symbols are kept. The oldest symbol
   // would be shifted out on the completing edge, so it is never observed.
   logic [SR_W-1:0]   sr;
   logic [CNT_W-1:0]  cnt;
   logic              last_sym;
   logic [DOUT_W-1:0] word_nxt;

   assign last_sym = din_en && (cnt == CNT_W'(RATIO - 1));
   assign word_nxt = {sr, din};

   // Symbol counter: advances per accepted symbol and wraps naturally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (din_en) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // Shift register: the newest symbol enters at the LSB end and older
   // symbols move toward the MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr <= '0;
      end else if (din_en) begin
         sr <= word_nxt[SR_W-1:0];
      end
   end

   // Output word register: loads only on word completion and holds otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout <= '0;
      end else if (last_sym) begin
         dout <= word_nxt;
      end
   end

   // Completion strobe: high for exactly one cycle per assembled word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_en <= 1'b0;
      end else begin
         dout_en <= last_sym;
      end
   end

endmodule

// File: tb/tb_data_consolidation.sv
// Directed plus randomized self-checking bench for data_consolidation.
module tb_data_consolidation;

   logic       clk;
   logic       rst_n;
   logic [1:0] din;
   logic       din_en;
   logic [7:0] dout;
   logic       dout_en;

   int checks   = 0;
   int failures = 0;

   data_consolidation dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .din     (din),
      .din_en  (din_en),
      .dout    (dout),
      .dout_en (dout_en)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle's inputs, let the edge happen, and sample 1 time unit later.
   task automatic step(input logic en, input logic [1:0] d);
      din_en = en;
      din    = d;
      @(posedge clk);
      #1;
   endtask

   // Feed one symbol and check the strobe and word that follow it.
   task automatic sym(input string tag, input logic [1:0] d, input logic exp_en,
                      input logic [7:0] exp_dout);
      step(1'b1, d);
      chk({tag, "_en"}, 32'(dout_en), 32'(exp_en));
      chk({tag, "_dout"}, 32'(dout), 32'(exp_dout));
   endtask

   logic [1:0] q[$];
   logic [7:0] exp_word;
   int         nvalid;
   int         nstrobe;
   logic       en_r;
   logic [1:0] d_r;

   initial begin
      rst_n  = 1'b0;
      din_en = 1'b0;
      din    = 2'b00;

      // Reset held while inputs toggle.
      for (int i = 0; i < 4; i++) begin
         step(i[0], 2'(i));
         chk("rst_hold_dout", 32'(dout), 32'h00);
         chk("rst_hold_en", 32'(dout_en), 32'h0);
      end
      rst_n = 1'b1;
      step(1'b0, 2'b00);

      // Single word.
      sym("w1_s0", 2'b11, 1'b0, 8'h00);
      sym("w1_s1", 2'b00, 1'b0, 8'h00);
      sym("w1_s2", 2'b10, 1'b0, 8'h00);
      sym("w1_s3", 2'b01, 1'b1, 8'hC9);
      step(1'b0, 2'b11);
      chk("w1_after_en", 32'(dout_en), 32'h0);
      chk("w1_hold", 32'(dout), 32'hC9);
      step(1'b0, 2'b10);
      chk("w1_hold2", 32'(dout), 32'hC9);

      // Streaming back-to-back.
      sym("st_0", 2'b01, 1'b0, 8'hC9);
      sym("st_1", 2'b10, 1'b0, 8'hC9);
      sym("st_2", 2'b11, 1'b0, 8'hC9);
      sym("st_3", 2'b00, 1'b1, 8'h6C);
      sym("st_4", 2'b00, 1'b0, 8'h6C);
      sym("st_5", 2'b01, 1'b0, 8'h6C);
      sym("st_6", 2'b10, 1'b0, 8'h6C);
      sym("st_7", 2'b11, 1'b1, 8'h1B);

      // Gaps mid-word.
      sym("gp_0", 2'b10, 1'b0, 8'h1B);
      sym("gp_1", 2'b10, 1'b0, 8'h1B);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 2'($urandom_range(0, 3)));
         chk("gp_idle_en", 32'(dout_en), 32'h0);
         chk("gp_idle_dout", 32'(dout), 32'h1B);
      end
      sym("gp_2", 2'b01, 1'b0, 8'h1B);
      sym("gp_3", 2'b01, 1'b1, 8'hA5);

      // Asynchronous reset mid-word clears outputs with no clock edge.
      sym("rm_0", 2'b00, 1'b0, 8'hA5);
      sym("rm_1", 2'b01, 1'b0, 8'hA5);
      sym("rm_2", 2'b10, 1'b0, 8'hA5);
      din_en = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_dout", 32'(dout), 32'h00);
      chk("async_rst_en", 32'(dout_en), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      sym("rm_p0", 2'b11, 1'b0, 8'h00);
      sym("rm_p1", 2'b11, 1'b0, 8'h00);
      sym("rm_p2", 2'b11, 1'b0, 8'h00);
      sym("rm_p3", 2'b11, 1'b1, 8'hFF);
      step(1'b0, 2'b00);
      chk("rm_after_en", 32'(dout_en), 32'h0);

      // Long random run against a symbol-history reference.
      rst_n = 1'b0;
      #1;
      @(negedge clk);
      rst_n = 1'b1;
      nvalid   = 0;
      nstrobe  = 0;
      exp_word = 8'h00;
      q.delete();
      for (int i = 0; i < 2000; i++) begin
         en_r = ($urandom_range(0, 3) != 0);
         d_r  = 2'($urandom_range(0, 3));
         step(en_r, d_r);
         if (en_r) begin
            q.push_back(d_r);
            if (q.size() > 4) void'(q.pop_front());
            nvalid++;
         end
         if (en_r && (nvalid % 4 == 0)) begin
            exp_word = {q[0], q[1], q[2], q[3]};
            chk("rnd_strobe", 32'(dout_en), 32'h1);
         end else begin
            chk("rnd_nostrobe", 32'(dout_en), 32'h0);
         end
         if (dout_en) nstrobe++;
         chk("rnd_dout", 32'(dout), 32'(exp_word));
      end
      chk("rnd_count", 32'(nstrobe), 32'(nvalid / 4));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/data_consolidation.md
Name:
data_consolidation

Overview:
- Serial-to-parallel packer: gathers four consecutive valid 2-bit symbols (din qualified by din_en) into one 8-bit word.
- Presents the word on dout with a single-cycle dout_en strobe.
- Sits between a narrow 2-bit stream source and byte-wide downstream logic.
- The first-received symbol lands in the MSBs.

Parameters:
- DIN_W, 2, input symbol width in bits.
- RATIO, 4, symbols per output word; must be a power of two ≥ 2.
- DOUT_W, DIN_W*RATIO (8), output word width; derived, not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  DIN_W (2)  input symbol; sampled only when din_en=1.
- din_en  input  1  symbol-valid qualifier, level-sensitive, one symbol per cycle while high.
- dout  output  DOUT_W (8)  assembled word, registered.
- dout_en  output  1  one-cycle strobe marking a new valid dout.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low. Assertion clears all state immediately; release is synchronous to clk.
- Reset values: dout=8'h00, dout_en=0, internal shift register=0, symbol counter=0.
- Shift register: on each rising edge with din_en=1, sr <= {sr[DOUT_W-DIN_W-1:0], din}. Older symbols move toward the MSB.
- Counter: log2(RATIO) bits (2 bits). It increments on every edge with din_en=1 and wraps 3->0. With din_en=0, counter and sr hold.
- Word completion: on the edge where din_en=1 and counter==RATIO-1:
  - dout <= {sr[DOUT_W-DIN_W-1:0], din}, i.e. the four most recent symbols, first symbol in dout[7:6] and latest in dout[1:0].
  - dout_en <= 1.
- Latency: dout/dout_en update on the same edge that samples the 4th symbol, so they are valid immediately after that edge (zero extra cycles).
- dout_en is high for exactly one cycle per word and is 0 on every other edge.
- Continuous din_en=1 gives one word every 4 cycles, back-to-back with no gaps.
- dout holds its last word between strobes; it changes only on word completion or reset.
- Gaps: din_en low mid-word pauses assembly. Partial symbols are retained and the word completes after the 4th valid symbol, however many idle cycles intervene.
- Framing: no resynchronisation other than reset. A partial word left when the stream stops stays pending and completes with the next symbols.
- Reset mid-word discards the partial word; the counter restarts at 0.
- din is ignored when din_en=0.

Decomposition:
- Shared package: DIN_W/RATIO defaults and a clog2-based counter-width constant.
- No sub-module needed. Counter, shift register and output register sit in one module (~120-150 lines).

Test Plan:
- Reset: hold rst_n=0 with din_en toggling -> dout=8'h00, dout_en=0 throughout. Assert rst_n asynchronously mid-cycle -> outputs clear without waiting for a clock edge.
- Single word: din_en=1 for 4 cycles, din=2'b11,2'b00,2'b10,2'b01 -> exactly one dout_en pulse after the 4th edge, dout=8'hC9, then dout_en=0 and dout holds 8'hC9.
- Streaming: continuous din_en=1, din=01,10,11,00,00,01,10,11 -> dout_en pulses every 4th cycle. dout=8'h6C, then 8'h1B. Each word must equal the last four symbols shifted MSB-first at every strobe.
- Gaps: symbols 10,10 then din_en=0 for 3 cycles (din toggling randomly), then 01,01 -> one strobe, dout=8'hA5. No strobe during the gap.
- Reset mid-word: feed 3 symbols, pulse rst_n low, then feed 11,11,11,11 -> dout=8'hFF strobed after the 4th post-reset symbol; the pre-reset partial word is lost.
- Long random run: ~2000 random symbols with random din_en -> dout_en count = floor(valid symbols/4), and every strobed dout matches a reference 8-bit shift model.
